// File: rtl/seq_mem_responder_if.sv
// Bus bundle for seq_mem_responder: load port, two read request/response ports,
// plus debug visibility of queue occupancy and the round-robin pointer.
interface seq_mem_responder_if;
   logic        load_val;
   logic        load_rdy;
   logic [63:0] load_msg;
   logic        req0_val;
   logic        req0_rdy;
   logic [31:0] req0_msg;
   logic        resp0_val;
   logic        resp0_rdy;
   logic [31:0] resp0_msg;
   logic        req1_val;
   logic        req1_rdy;
   logic [31:0] req1_msg;
   logic        resp1_val;
   logic        resp1_rdy;
   logic [31:0] resp1_msg;
   logic [1:0]  dbg_cnt0;
   logic [1:0]  dbg_cnt1;
   logic        dbg_rr;

   // A transfer happens on a rising clk edge where val && rdy; rdy never depends on msg.
   modport slave (
      input  load_val, load_msg,
      input  req0_val, req0_msg, resp0_rdy,
      input  req1_val, req1_msg, resp1_rdy,
      output load_rdy, req0_rdy, req1_rdy,
      output resp0_val, resp0_msg, resp1_val, resp1_msg,
      output dbg_cnt0, dbg_cnt1, dbg_rr
   );

   modport master (
      output load_val, load_msg,
      output req0_val, req0_msg, resp0_rdy,
      output req1_val, req1_msg, resp1_rdy,
      input  load_rdy, req0_rdy, req1_rdy,
      input  resp0_val, resp0_msg, resp1_val, resp1_msg,
      input  dbg_cnt0, dbg_cnt1, dbg_rr
   );
endinterface

// File: rtl/seq_mem_responder.sv
// Two-port packed-sequence memory responder: load-priority grant, round-robin reads,
// one-stage synchronous read pipeline feeding a 2-entry response FIFO per port.
module seq_mem_responder #(
   parameter int NWORDS = 256,
   parameter int AW     = 8
) (
   input logic            clk,
   input logic            reset,
   seq_mem_responder_if.slave bus
);

   logic [31:0] mem_q [NWORDS];
   logic [31:0] fifo_q [2][2];
   logic [1:0]  cnt_q [2];
   logic [1:0]  cnt_d [2];
   logic [1:0]  rptr_q, wptr_q;
   logic        rd_vld_q, rd_tag_q;
   logic [31:0] rd_data_q;
   logic        rr_q, rr_d;

   logic [1:0]  req_val, resp_rdy;
   logic [31:0] req_msg [2];
   logic [1:0]  resp_val, deq, enq, credit_ok, want, gnt;
   logic [2:0]  used [2];
   logic        load_gnt;
   logic [31:0] rd_addr, ld_addr;
   logic        rd_in_range, ld_in_range;
   logic        unused_bits;

   assign req_val    = {bus.req1_val, bus.req0_val};
   assign resp_rdy   = {bus.resp1_rdy, bus.resp0_rdy};
   assign req_msg[0] = bus.req0_msg;
   assign req_msg[1] = bus.req1_msg;

   // A dequeue in the same cycle frees a slot, so a lone port keeps 1 req/cycle.
   always_comb begin
      resp_val  = '0;
      deq       = '0;
      enq       = '0;
      credit_ok = '0;
      want      = '0;
      used      = '{default: '0};
      cnt_d     = cnt_q;
      for (int p = 0; p < 2; p++) begin
         resp_val[p]  = (cnt_q[p] != 2'd0) && !reset;
         deq[p]       = resp_val[p] && resp_rdy[p];
         enq[p]       = rd_vld_q && (rd_tag_q == 1'(p));
         used[p]      = {1'b0, cnt_q[p]} + {2'b0, enq[p]} - {2'b0, deq[p]};
         credit_ok[p] = used[p] < 3'd2;
         want[p]      = req_val[p] && credit_ok[p] && !reset;
         cnt_d[p]     = cnt_q[p] + {1'b0, enq[p]} - {1'b0, deq[p]};
      end
   end

   always_comb begin
      load_gnt = bus.load_val && !reset;
      gnt      = 2'b00;
      rr_d     = rr_q;
      if (!load_gnt) begin
         if (!rr_q) begin
            if (want[0])      gnt = 2'b01;
            else if (want[1]) gnt = 2'b10;
         end else begin
            if (want[1])      gnt = 2'b10;
            else if (want[0]) gnt = 2'b01;
         end
      end
      if (gnt[0])      rr_d = 1'b1;
      else if (gnt[1]) rr_d = 1'b0;
   end

   assign rd_addr     = gnt[1] ? req_msg[1] : req_msg[0];
   assign ld_addr     = bus.load_msg[63:32];
   assign rd_in_range = (rd_addr[31:AW+2] == '0);
   assign ld_in_range = (ld_addr[31:AW+2] == '0);
   assign unused_bits = ^{rd_addr[1:0], ld_addr[1:0]};

   // Storage and read data are never reset; only control state is.
   always_ff @(posedge clk) begin
      if (load_gnt && ld_in_range)
         mem_q[ld_addr[AW+1:2]] <= bus.load_msg[31:0];
      if (|gnt)
         rd_data_q <= rd_in_range ? mem_q[rd_addr[AW+1:2]] : 32'h0;
      for (int p = 0; p < 2; p++)
         if (enq[p]) fifo_q[p][wptr_q[p]] <= rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld_q <= 1'b0;
         rd_tag_q <= 1'b0;
         rr_q     <= 1'b0;
         rptr_q   <= 2'b00;
         wptr_q   <= 2'b00;
         cnt_q    <= '{default: '0};
      end else begin
         rd_vld_q <= |gnt;
         rd_tag_q <= gnt[1];
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         for (int p = 0; p < 2; p++) begin
            if (enq[p]) wptr_q[p] <= ~wptr_q[p];
            if (deq[p]) rptr_q[p] <= ~rptr_q[p];
         end
      end
   end

   assign bus.load_rdy  = load_gnt;
   assign bus.req0_rdy  = gnt[0];
   assign bus.req1_rdy  = gnt[1];
   assign bus.resp0_val = resp_val[0];
   assign bus.resp1_val = resp_val[1];
   assign bus.resp0_msg = resp_val[0] ? fifo_q[0][rptr_q[0]] : 32'h0;
   assign bus.resp1_msg = resp_val[1] ? fifo_q[1][rptr_q[1]] : 32'h0;
   assign bus.dbg_cnt0  = cnt_q[0];
   assign bus.dbg_cnt1  = cnt_q[1];
   assign bus.dbg_rr    = rr_q;

endmodule

// File: tb/tb_seq_mem_responder.sv
// Directed bench for seq_mem_responder: latency, arbitration, credit stall,
// load priority, out-of-range handling and mid-operation reset.
module tb_seq_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_mem_responder_if bus();
  seq_mem_responder #(.NWORDS(256), .AW(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted response is compared against the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp0_val && bus.resp0_rdy) begin
        if (exp0_q.size() == 0) check_eq("resp0_extra", bus.resp0_val, 0);
        else check_eq("resp0_data", bus.resp0_msg, exp0_q.pop_front());
      end
      if (bus.resp1_val && bus.resp1_rdy) begin
        if (exp1_q.size() == 0) check_eq("resp1_extra", bus.resp1_val, 0);
        else check_eq("resp1_data", bus.resp1_msg, exp1_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_val = 0; bus.load_msg = '0;
    bus.req0_val = 0; bus.req0_msg = '0; bus.resp0_rdy = 0;
    bus.req1_val = 0; bus.req1_msg = '0; bus.resp1_rdy = 0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_val = 1;
    bus.load_msg = {a, d};
    #1;
    check_eq("load_rdy", bus.load_rdy, 1);
    tick();
    bus.load_val = 0;
  endtask

  task automatic read_port(input int p, input logic [31:0] a, input logic [31:0] exp);
    bit done = 0;
    if (p == 0) begin bus.req0_val = 1; bus.req0_msg = a; end
    else begin bus.req1_val = 1; bus.req1_msg = a; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if ((p == 0 && bus.req0_rdy) || (p == 1 && bus.req1_rdy)) begin
        done = 1;
        if (p == 0) exp0_q.push_back(exp);
        else exp1_q.push_back(exp);
      end
      tick();
    end
    if (p == 0) bus.req0_val = 0;
    else bus.req1_val = 0;
    check_eq("req_accepted", done, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  logic [31:0] a0 [3];
  logic [31:0] d0 [3];
  logic [31:0] a1 [3];
  logic [31:0] d1 [3];
  int idx0, idx1;

  initial begin
    a0 = '{32'h00, 32'h04, 32'h14};
    d0 = '{32'h11111111, 32'h22222222, 32'hDEADBEEF};
    a1 = '{32'h04, 32'h14, 32'h00};
    d1 = '{32'h22222222, 32'hDEADBEEF, 32'h11111111};

    // reset state; requests during reset must not be granted
    idle_inputs();
    reset = 1;
    bus.load_val = 1;
    bus.req0_val = 1;
    tick();
    check_eq("rst_load_rdy", bus.load_rdy, 0);
    check_eq("rst_req0_rdy", bus.req0_rdy, 0);
    idle_inputs();
    tick();
    reset = 0;
    tick();
    check_eq("rst_resp0_val", bus.resp0_val, 0);
    check_eq("rst_resp0_msg", bus.resp0_msg, 0);
    check_eq("rst_resp1_val", bus.resp1_val, 0);
    check_eq("rst_resp1_msg", bus.resp1_msg, 0);
    check_eq("rst_cnt0", bus.dbg_cnt0, 0);
    check_eq("rst_rr", bus.dbg_rr, 0);

    // minimum latency of 2
    load_word(32'h14, 32'hDEADBEEF);
    bus.req0_val = 1;
    bus.req0_msg = 32'h14;
    #1;
    check_eq("t1_req0_rdy", bus.req0_rdy, 1);
    exp0_q.push_back(32'hDEADBEEF);
    tick();
    bus.req0_val = 0;
    check_eq("t1_val_t1", bus.resp0_val, 0);
    tick();
    check_eq("t1_val_t2", bus.resp0_val, 1);
    check_eq("t1_msg_t2", bus.resp0_msg, 32'hDEADBEEF);
    bus.resp0_rdy = 1;
    tick();
    check_eq("t1_drained", exp0_q.size(), 0);

    // round-robin alternation from a fresh pointer
    load_word(32'h00, 32'h11111111);
    load_word(32'h04, 32'h22222222);
    reset = 1;
    tick();
    reset = 0;
    bus.resp1_rdy = 1;
    bus.req0_val = 1; bus.req0_msg = 32'h00;
    bus.req1_val = 1; bus.req1_msg = 32'h04;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t2_grant", {bus.req1_rdy, bus.req0_rdy}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (bus.req0_rdy) exp0_q.push_back(32'h11111111);
      if (bus.req1_rdy) exp1_q.push_back(32'h22222222);
      tick();
    end
    bus.req0_val = 0;
    bus.req1_val = 0;
    wait_cycles(4);
    check_eq("t2_q0_drained", exp0_q.size(), 0);
    check_eq("t2_q1_drained", exp1_q.size(), 0);

    // port 1 stalled: exactly 2 credits, port 0 keeps streaming
    bus.resp1_rdy = 0;
    idx0 = 0;
    idx1 = 0;
    bus.req0_val = 1;
    bus.req1_val = 1;
    for (int i = 0; i < 10; i++) begin
      bus.req0_msg = a0[idx0 % 3];
      bus.req1_msg = a1[idx1 % 3];
      @(negedge clk);
      if (bus.req0_rdy) begin exp0_q.push_back(d0[idx0 % 3]); idx0++; end
      if (bus.req1_rdy) begin exp1_q.push_back(d1[idx1 % 3]); idx1++; end
      tick();
    end
    bus.req0_val = 0;
    bus.req1_val = 0;
    check_eq("t3_p1_accepts", idx1, 2);
    check_eq("t3_p0_accepts", idx0, 8);
    wait_cycles(3);
    check_eq("t3_cnt1_full", bus.dbg_cnt1, 2);
    check_eq("t3_resp1_head", bus.resp1_msg, 32'h22222222);
    bus.resp1_rdy = 1;
    wait_cycles(4);
    check_eq("t3_q1_drained", exp1_q.size(), 0);
    check_eq("t3_q0_drained", exp0_q.size(), 0);
    check_eq("t3_cnt1_empty", bus.dbg_cnt1, 0);

    // load wins over a same-cycle read; the following read sees new data
    load_word(32'h08, 32'hAAAA0000);
    bus.load_val = 1; bus.load_msg = {32'h08, 32'h0000BBBB};
    bus.req0_val = 1; bus.req0_msg = 32'h08;
    #1;
    check_eq("t4_load_rdy", bus.load_rdy, 1);
    check_eq("t4_req0_blocked", bus.req0_rdy, 0);
    tick();
    bus.load_val = 0;
    @(negedge clk);
    check_eq("t4_req0_rdy", bus.req0_rdy, 1);
    exp0_q.push_back(32'h0000BBBB);
    tick();
    bus.req0_val = 0;
    wait_cycles(3);
    check_eq("t4_drained", exp0_q.size(), 0);

    // out-of-range reads/loads and an unaligned read
    read_port(0, 32'h00000400, 32'h0);
    load_word(32'h00000400, 32'hFFFFFFFF);
    read_port(0, 32'h00000000, 32'h11111111);
    read_port(1, 32'h00000017, 32'hDEADBEEF);
    read_port(0, 32'h80000014, 32'h0);
    wait_cycles(4);
    check_eq("t5_q0_drained", exp0_q.size(), 0);
    check_eq("t5_q1_drained", exp1_q.size(), 0);

    // reset with one response queued and one in flight
    bus.resp0_rdy = 0;
    bus.req0_val = 1;
    bus.req0_msg = 32'h04;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t6_req0_rdy", bus.req0_rdy, 1);
      tick();
    end
    @(negedge clk);
    check_eq("t6_credit_full", bus.req0_rdy, 0);
    check_eq("t6_cnt0_one", bus.dbg_cnt0, 1);
    reset = 1;
    bus.req0_val = 0;
    tick();
    tick();
    reset = 0;
    exp0_q.delete();
    bus.resp0_rdy = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t6_resp0_val", bus.resp0_val, 0);
      check_eq("t6_cnt0", bus.dbg_cnt0, 0);
      tick();
    end

    check_eq("end_q0_empty", exp0_q.size(), 0);
    check_eq("end_q1_empty", exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
